// File: rtl/sha1_msg_padder.sv
// Byte-stream front end for the two-block SHA-1 core: buffers a 56..119 byte message,
// applies 0x80 / zero / 64-bit length padding and issues the restart train. Optional: SHA1_PAD_ERR_CNT_EN.
module sha1_msg_padder #(
    parameter int RESTART_CYCLES = 16,
    parameter int MIN_LEN        = 56,
    parameter int MAX_LEN        = 119
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    input  logic          sha_ready,
    output logic [1023:0] data_out,
    output logic          restart,
    output logic          busy,
    output logic          len_err
`ifdef SHA1_PAD_ERR_CNT_EN
    ,
    output logic [7:0]    err_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, COLLECT, PAD, WAIT_RDY, ISSUE, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [6:0]    cnt;
    logic [5:0]    rcnt;
    logic [7:0]    buffer [128];
    logic [1023:0] padded;
    logic [9:0]    pos;
    logic [15:0]   len_bits;
    logic          hs;
    logic          len_ok;

    assign hs       = s_valid && s_ready;
    assign len_ok   = (cnt >= 7'(MIN_LEN)) && (cnt <= 7'(MAX_LEN));
    assign len_bits = {6'b0, cnt, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (hs) state_nxt = s_last ? PAD : COLLECT;
            COLLECT:  if (hs) begin
                          if (s_last)                  state_nxt = PAD;
                          else if (cnt == 7'(MAX_LEN)) state_nxt = DRAIN;
                      end
            PAD:      state_nxt = len_ok ? WAIT_RDY : IDLE;
            WAIT_RDY: if (sha_ready) state_nxt = ISSUE;
            ISSUE:    if (rcnt == 6'(RESTART_CYCLES - 1)) state_nxt = IDLE;
            DRAIN:    if (hs && s_last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == IDLE) || (state == COLLECT) || (state == DRAIN);
        restart = (state == ISSUE);
        busy    = (state != IDLE);
        len_err = ((state == PAD) && !len_ok) || ((state == DRAIN) && hs && s_last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            rcnt <= '0;
        end else begin
            if (hs && state == IDLE)         cnt <= 7'd1;
            else if (hs && state == COLLECT) cnt <= cnt + 7'd1;
            rcnt <= (state == ISSUE) ? rcnt + 6'd1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (hs && state == IDLE)         buffer[0]   <= s_data;
        else if (hs && state == COLLECT) buffer[cnt] <= s_data;
    end

    // Byte p lands big-endian within 32-bit word p/4; length occupies bytes 126/127 only.
    always_comb begin
        padded = '0;
        pos    = '0;
        for (int unsigned p = 0; p < 120; p++) begin
            pos = 10'(32 * (p / 4) + 8 * (3 - p % 4));
            if (p < 32'(cnt))       padded[pos +: 8] = buffer[7'(p)];
            else if (p == 32'(cnt)) padded[pos +: 8] = 8'h80;
        end
        padded[1007:1000] = len_bits[15:8];
        padded[999:992]   = len_bits[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                     data_out <= '0;
        else if (state == PAD && len_ok) data_out <= padded;
    end

`ifdef SHA1_PAD_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                         err_cnt <= '0;
        else if (len_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: padding layout, length errors, drain, restart handshake, mid-message reset.
module tb_sha1_msg_padder;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          sha_ready = 1'b1;
    logic [1023:0] data_out;
    logic          restart;
    logic          busy;
    logic          len_err;
`ifdef SHA1_PAD_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    sha1_msg_padder #(.RESTART_CYCLES(16), .MIN_LEN(56), .MAX_LEN(119)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .sha_ready(sha_ready), .data_out(data_out), .restart(restart),
        .busy(busy), .len_err(len_err)
`ifdef SHA1_PAD_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int restart_total = 0;
    int len_err_total = 0;

    always @(negedge clk) begin
        if (restart) restart_total++;
        if (len_err) len_err_total++;
    end

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference padding: byte list first, then packed four bytes per big-endian word.
    function automatic logic [1023:0] model(input int n, input logic [7:0] v);
        logic [7:0]    b [128];
        logic [63:0]   bits;
        logic [1023:0] m;
        bits = 64'(n) * 64'd8;
        for (int i = 0; i < 128; i++) b[i] = (i < n) ? v : (i == n) ? 8'h80 : 8'h00;
        for (int j = 0; j < 8; j++) b[120 + j] = bits[63 - 8 * j -: 8];
        for (int w = 0; w < 32; w++) m[32 * w +: 32] = {b[4 * w], b[4 * w + 1], b[4 * w + 2], b[4 * w + 3]};
        return m;
    endfunction

    bit ready_ok;

    task automatic send(input int n, input logic [7:0] v, input bit mark_last);
        ready_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_data  = v;
            s_last  = mark_last && (i == n - 1);
            @(negedge clk);
            if (!s_ready) ready_ok = 1'b0;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check(tag, 1024'(done), 1024'(1'b1));
    endtask

    int r0, e0;
    logic [1023:0] prev;
    bit r_low, sr_low;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", 1024'(s_ready), 1024'(1'b1));
        check("rst_restart", 1024'(restart), 1024'(1'b0));
        check("rst_busy", 1024'(busy), 1024'(1'b0));
        check("rst_len_err", 1024'(len_err), 1024'(1'b0));
        check("rst_data_out", data_out, '0);

        // 56 x 0x61
        r0 = restart_total; e0 = len_err_total;
        send(56, 8'h61, 1'b1);
        wait_idle("m56_idle");
        check("m56_ready", 1024'(ready_ok), 1024'(1'b1));
        check("m56_b0", 1024'(data_out[31:24]), 1024'(8'h61));
        check("m56_marker", 1024'(data_out[479:472]), 1024'(8'h80));
        check("m56_len_hi", 1024'(data_out[1007:1000]), 1024'(8'h01));
        check("m56_len_lo", 1024'(data_out[999:992]), 1024'(8'hC0));
        check("m56_full", data_out, model(56, 8'h61));
        check("m56_restart", 1024'(restart_total - r0), 1024'(16));
        check("m56_len_err", 1024'(len_err_total - e0), 1024'(0));

        // 119 x 0x00
        r0 = restart_total;
        send(119, 8'h00, 1'b1);
        wait_idle("m119_idle");
        check("m119_marker", 1024'(data_out[935:928]), 1024'(8'h80));
        check("m119_len_hi", 1024'(data_out[1007:1000]), 1024'(8'h03));
        check("m119_len_lo", 1024'(data_out[999:992]), 1024'(8'hB8));
        check("m119_full", data_out, model(119, 8'h00));
        check("m119_restart", 1024'(restart_total - r0), 1024'(16));

        // 55 bytes: too short
        prev = data_out; r0 = restart_total; e0 = len_err_total;
        send(55, 8'h33, 1'b1);
        wait_idle("m55_idle");
        check("m55_len_err", 1024'(len_err_total - e0), 1024'(1));
        check("m55_restart", 1024'(restart_total - r0), 1024'(0));
        check("m55_hold", data_out, prev);

        // 125 bytes: overflow drained
        r0 = restart_total; e0 = len_err_total;
        send(125, 8'h44, 1'b1);
        wait_idle("m125_idle");
        check("m125_ready", 1024'(ready_ok), 1024'(1'b1));
        check("m125_len_err", 1024'(len_err_total - e0), 1024'(1));
        check("m125_restart", 1024'(restart_total - r0), 1024'(0));
        check("m125_hold", data_out, prev);

        r0 = restart_total;
        send(64, 8'h5A, 1'b1);
        wait_idle("m64_idle");
        check("m64_len_hi", 1024'(data_out[1007:1000]), 1024'(8'h02));
        check("m64_len_lo", 1024'(data_out[999:992]), 1024'(8'h00));
        check("m64_full", data_out, model(64, 8'h5A));
        check("m64_restart", 1024'(restart_total - r0), 1024'(16));

        // sha_ready held low
        #1 sha_ready = 1'b0;
        r0 = restart_total;
        send(60, 8'h11, 1'b1);
        r_low = 1'b1; sr_low = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (restart) r_low = 1'b0;
            if (s_ready) sr_low = 1'b0;
        end
        check("wait_restart_low", 1024'(r_low), 1024'(1'b1));
        check("wait_s_ready_low", 1024'(sr_low), 1024'(1'b1));
        @(posedge clk); #1 sha_ready = 1'b1;
        @(negedge clk);
        check("wait_restart_same", 1024'(restart), 1024'(1'b0));
        @(negedge clk);
        check("wait_restart_next", 1024'(restart), 1024'(1'b1));
        wait_idle("wait_idle");
        check("wait_restart_cnt", 1024'(restart_total - r0), 1024'(16));
        check("wait_full", data_out, model(60, 8'h11));

        // reset during byte 30
        send(30, 8'hC3, 1'b0);
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 8'hC3; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        check("mrst_s_ready", 1024'(s_ready), 1024'(1'b1));
        check("mrst_busy", 1024'(busy), 1024'(1'b0));
        check("mrst_restart", 1024'(restart), 1024'(1'b0));
        check("mrst_len_err", 1024'(len_err), 1024'(1'b0));
        check("mrst_data_out", data_out, '0);
        r0 = restart_total;
        send(60, 8'h77, 1'b1);
        wait_idle("m60_idle");
        check("m60_len_hi", 1024'(data_out[1007:1000]), 1024'(8'h01));
        check("m60_len_lo", 1024'(data_out[999:992]), 1024'(8'hE0));
        check("m60_full", data_out, model(60, 8'h77));
        check("m60_restart", 1024'(restart_total - r0), 1024'(16));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
